max7219_driver: RTL and testbench
=================================

MAX7219_DRIVER -- requirements
Module: max7219_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; system clocks per serial tick, legal range 2..255.
REQ-002 SHALL have parameter INTENSITY, default 4'h8; value written to the MAX7219 intensity register (0x0A).
REQ-003 SHALL have port CLOCK_50  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_InHigh  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port drv_start_in  input  1  refresh request, sampled each clock.
REQ-006 SHALL have port drv_data_in  input  8  column data returned by the image column-select stage.
REQ-007 SHALL have port drv_select_add_out  output  3  column index driven to the image column-select stage.
REQ-008 SHALL have port max_din_out  output  1  serial data to MAX7219 DIN.
REQ-009 SHALL have port max_clk_out  output  1  serial clock to MAX7219 CLK.
REQ-010 SHALL have port max_load_out  output  1  MAX7219 LOAD/CS.
REQ-011 SHALL have port drv_busy_out  output  1  high while init or refresh is in progress.
REQ-012 SHALL have port drv_done_out  output  1  one-clock pulse at the end of each refresh.

Function
REQ-013 SHALL generate a tick every CLK_DIV clocks from a divider counter that is cleared on every state entry.
REQ-014 SHALL send each frame as 16 bits, MSB first: {4'h0, addr[3:0], data[7:0]}.
REQ-015 SHALL use 2 ticks per bit: tick A drives max_clk_out=0 and presents the bit on max_din_out; tick B drives max_clk_out=1.
REQ-016 SHALL hold max_load_out=0 during shifting, then after bit 0 drive max_clk_out=0 and max_load_out=1 for exactly 2 ticks (LATCH), then return max_load_out=0.
REQ-017 SHALL make one frame last 34 ticks, i.e. 34*CLK_DIV clocks.
REQ-018 SHALL use states RST, INIT_LOAD, SHIFT, LATCH, IDLE, ROW_SEL, ROW_LOAD.
REQ-019 SHALL go RST -> INIT_LOAD on the first clock after reset deasserts.
REQ-020 SHALL send 5 init frames in order: 0x0C01, 0x0900, {0x0A,4'h0,INTENSITY}, 0x0B07, 0x0F00.
REQ-021 SHALL go to IDLE after the LATCH of the 5th init frame.
REQ-022 SHALL, in IDLE with drv_start_in=1, go to ROW_SEL with row=0.
REQ-023 SHALL, in ROW_SEL, drive drv_select_add_out=row for one clock, then go to ROW_LOAD.
REQ-024 SHALL, in ROW_LOAD, capture {4'h0, row+1, drv_data_in} into the shift register and go to SHIFT.
REQ-025 SHALL hold drv_select_add_out stable at row from ROW_SEL through the end of LATCH.
REQ-026 SHALL compute row as 3 bits and the digit register address as 4 bits, row+1, giving 1..8 with no overflow.
REQ-027 SHALL, after LATCH of row r<7, go to ROW_SEL with row=r+1.
REQ-028 SHALL, after LATCH of row 7, pulse drv_done_out for 1 clock, go to IDLE and set row=0.
REQ-029 SHALL ignore drv_start_in outside IDLE, without queuing it; start held high gives back-to-back refreshes.
REQ-030 SHALL hold drv_busy_out=1 in every state except IDLE.
REQ-031 SHALL treat drv_data_in as combinational from drv_select_add_out, valid within the ROW_SEL clock.

Reset
REQ-032 SHALL, on RESET_InHigh=1 at a clock edge, set max_din_out=0, max_clk_out=0, max_load_out=0, drv_select_add_out=0, drv_busy_out=1, drv_done_out=0, state=RST, and clear the divider, bit and frame counters.
REQ-033 SHALL, on reset mid-frame, take effect at the next edge with no completing LATCH, and afterwards restart the full init sequence.
REQ-034 SHALL keep the outputs at their reset values for as long as reset is held.

Verification
REQ-035 SHALL cover: release reset, CLK_DIV=4 -> 5 frames decode as 0x0C01, 0x0900, 0x0A08, 0x0B07, 0x0F00; IDLE reached after 5*34*4=680 clocks plus entry clocks; busy falls.
REQ-036 SHALL cover: one-clock start, column model returning 8'hA0+sel -> frames 0x01A0, 0x02A1, ..., 0x08A7; exactly one drv_done_out pulse; busy=0 afterwards.
REQ-037 SHALL cover: every bit -> DIN stable across each max_clk_out rising edge; LOAD high for exactly 2*CLK_DIV clocks per frame; no max_clk_out rise while LOAD=1.
REQ-038 SHALL cover: start pulsed during init and mid-refresh -> ignored; frame count unchanged; done count=1 per accepted start.
REQ-039 SHALL cover: reset asserted at bit 9 of row 3 -> all outputs at reset values next clock; no LOAD pulse for that frame; init sequence resends from 0x0C01.
REQ-040 SHALL cover: start held high for 2 refreshes, CLK_DIV=2 -> 16 row frames with no idle gap greater than 2 clocks between refreshes; 2 done pulses.

Source files
------------

// File: rtl/max7219_driver.sv
// rtl/max7219_driver.sv - MAX7219 init + 8-row refresh serial driver
// Ports:
//   CLOCK_50            system clock, rising edge
//   RESET_InHigh        synchronous active-high reset
//   drv_start_in        refresh request (honoured only in IDLE)
//   drv_data_in         column byte for the row on drv_select_add_out
//   drv_select_add_out  row index presented to the column-select stage
//   max_din_out         serial data to MAX7219 DIN
//   max_clk_out         serial clock to MAX7219 CLK
//   max_load_out        MAX7219 LOAD/CS
//   drv_busy_out        high in every state except IDLE
//   drv_done_out        one-clock pulse after the last row frame
module max7219_driver #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_InHigh,
    input  logic       drv_start_in,
    input  logic [7:0] drv_data_in,
    output logic [2:0] drv_select_add_out,
    output logic       max_din_out,
    output logic       max_clk_out,
    output logic       max_load_out,
    output logic       drv_busy_out,
    output logic       drv_done_out
);

    typedef enum logic [2:0] {
        ST_RST, ST_INIT_LOAD, ST_SHIFT, ST_LATCH, ST_IDLE, ST_ROW_SEL, ST_ROW_LOAD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_idx;
    logic        phase_b;     // last tick applied was tick B (clock high)
    logic        latch_tick;  // second LATCH tick in progress
    logic [2:0]  frame_idx;
    logic [2:0]  row;
    logic        in_refresh;  // LATCH exit goes to the row path, not the init path
    logic [15:0] shreg;
    logic [15:0] init_word;
    logic [15:0] row_word;
    logic        tick;

    assign tick               = (div_cnt == DIV_LAST);
    assign drv_select_add_out = row;
    assign row_word           = {4'h0, {1'b0, row} + 4'd1, drv_data_in};

    always_comb begin
        init_word = 16'h0000;
        case (frame_idx)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = 16'h0900;
            3'd2:    init_word = {8'h0A, 4'h0, INTENSITY};
            3'd3:    init_word = 16'h0B07;
            3'd4:    init_word = 16'h0F00;
            default: init_word = 16'h0000;
        endcase
    end

    // Loading a frame applies the first tick A (bit 15 on DIN, CLK low) at once,
    // so SHIFT is exactly 32 ticks and the whole frame 34 ticks.
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state        <= ST_RST;
            div_cnt      <= 8'd0;
            bit_idx      <= 4'd0;
            phase_b      <= 1'b0;
            latch_tick   <= 1'b0;
            frame_idx    <= 3'd0;
            row          <= 3'd0;
            in_refresh   <= 1'b0;
            shreg        <= 16'h0000;
            max_din_out  <= 1'b0;
            max_clk_out  <= 1'b0;
            max_load_out <= 1'b0;
            drv_busy_out <= 1'b1;
            drv_done_out <= 1'b0;
        end else begin
            drv_done_out <= 1'b0;
            case (state)
                ST_RST: begin
                    frame_idx <= 3'd0;
                    state     <= ST_INIT_LOAD;
                end
                ST_INIT_LOAD: begin
                    in_refresh  <= 1'b0;
                    shreg       <= init_word;
                    max_din_out <= init_word[15];
                    max_clk_out <= 1'b0;
                    bit_idx     <= 4'd15;
                    phase_b     <= 1'b0;
                    div_cnt     <= 8'd0;
                    state       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        div_cnt <= 8'd0;
                        if (!phase_b) begin
                            max_clk_out <= 1'b1;
                            phase_b     <= 1'b1;
                        end else if (bit_idx == 4'd0) begin
                            max_clk_out  <= 1'b0;
                            max_load_out <= 1'b1;
                            latch_tick   <= 1'b0;
                            state        <= ST_LATCH;
                        end else begin
                            bit_idx     <= bit_idx - 4'd1;
                            max_din_out <= shreg[bit_idx - 4'd1];
                            max_clk_out <= 1'b0;
                            phase_b     <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        div_cnt <= 8'd0;
                        if (!latch_tick) begin
                            latch_tick <= 1'b1;
                        end else begin
                            latch_tick   <= 1'b0;
                            max_load_out <= 1'b0;
                            if (!in_refresh) begin
                                if (frame_idx == 3'd4) begin
                                    drv_busy_out <= 1'b0;
                                    state        <= ST_IDLE;
                                end else begin
                                    frame_idx <= frame_idx + 3'd1;
                                    state     <= ST_INIT_LOAD;
                                end
                            end else if (row == 3'd7) begin
                                row          <= 3'd0;
                                in_refresh   <= 1'b0;
                                drv_done_out <= 1'b1;
                                drv_busy_out <= 1'b0;
                                state        <= ST_IDLE;
                            end else begin
                                row   <= row + 3'd1;
                                state <= ST_ROW_SEL;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (drv_start_in) begin
                        row          <= 3'd0;
                        drv_busy_out <= 1'b1;
                        state        <= ST_ROW_SEL;
                    end
                end
                ST_ROW_SEL: begin
                    state <= ST_ROW_LOAD;
                end
                ST_ROW_LOAD: begin
                    in_refresh  <= 1'b1;
                    shreg       <= row_word;
                    max_din_out <= row_word[15];
                    max_clk_out <= 1'b0;
                    bit_idx     <= 4'd15;
                    phase_b     <= 1'b0;
                    div_cnt     <= 8'd0;
                    state       <= ST_SHIFT;
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_driver.sv
// tb/tb_max7219_driver.sv - self-checking bench for max7219_driver
module tb_max7219_driver;

    logic       CLOCK_50 = 1'b0;
    logic       rst1 = 1'b1, rst2 = 1'b1, start1 = 1'b0, start2 = 1'b0;
    logic [7:0] data1, data2;
    logic [2:0] sel1, sel2;
    logic       din1, clk1, load1, busy1, done1;
    logic       din2, clk2, load2, busy2, done2;

    logic [7:0] col_mem [8];
    logic       mon_sel = 1'b0;
    int         errors = 0;
    int         checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    assign data1 = col_mem[sel1];
    assign data2 = col_mem[sel2];

    max7219_driver #(.CLK_DIV(4), .INTENSITY(4'h8)) u_dut (
        .CLOCK_50(CLOCK_50), .RESET_InHigh(rst1), .drv_start_in(start1),
        .drv_data_in(data1), .drv_select_add_out(sel1), .max_din_out(din1),
        .max_clk_out(clk1), .max_load_out(load1), .drv_busy_out(busy1),
        .drv_done_out(done1));

    max7219_driver #(.CLK_DIV(2), .INTENSITY(4'h3)) u_dut2 (
        .CLOCK_50(CLOCK_50), .RESET_InHigh(rst2), .drv_start_in(start2),
        .drv_data_in(data2), .drv_select_add_out(sel2), .max_din_out(din2),
        .max_clk_out(clk2), .max_load_out(load2), .drv_busy_out(busy2),
        .drv_done_out(done2));

    // Observed DUT selected by mon_sel
    logic m_din, m_clk, m_load, m_busy, m_done, m_rst;
    int   cur_div;
    assign m_din  = mon_sel ? din2  : din1;
    assign m_clk  = mon_sel ? clk2  : clk1;
    assign m_load = mon_sel ? load2 : load1;
    assign m_busy = mon_sel ? busy2 : busy1;
    assign m_done = mon_sel ? done2 : done1;
    assign m_rst  = mon_sel ? rst2  : rst1;
    assign cur_div = mon_sel ? 2 : 4;

    // Serial decoder: frames are whatever 16 bits were clocked in when LOAD rises
    logic [15:0] frames [$];
    logic [15:0] acc = 16'h0;
    int   bitcnt = 0, load_len = 0, done_count = 0;
    int   gap_cur = 0, gap_max = 0;
    logic gap_run = 1'b0;
    logic p_din = 1'b0, p_clk = 1'b0, p_load = 1'b0, p_done = 1'b0;

    always @(negedge CLOCK_50) begin
        if (m_rst) begin
            acc    = 16'h0;
            bitcnt = 0;
        end else begin
            if (m_clk && !p_clk) begin
                checks++;
                assert (m_din === p_din) else begin
                    errors++;
                    $error("FAIL din_stable observed=%0b expected=%0b", m_din, p_din);
                end
                checks++;
                assert (m_load === 1'b0) else begin
                    errors++;
                    $error("FAIL clk_rise_in_load observed=%0b expected=0", m_load);
                end
                acc = {acc[14:0], m_din};
                bitcnt++;
            end
            if (m_load && !p_load) begin
                frames.push_back(acc);
                checks++;
                assert (bitcnt == 16) else begin
                    errors++;
                    $error("FAIL bits_per_frame observed=%0d expected=16", bitcnt);
                end
                bitcnt   = 0;
                load_len = 0;
            end
            if (m_load) load_len++;
            if (!m_load && p_load) begin
                checks++;
                assert (load_len == 2 * cur_div) else begin
                    errors++;
                    $error("FAIL load_width observed=%0d expected=%0d", load_len, 2 * cur_div);
                end
            end
            if (m_done) begin
                done_count++;
                checks++;
                assert (p_done === 1'b0) else begin
                    errors++;
                    $error("FAIL done_width observed=2+ expected=1");
                end
                gap_run = 1'b1;
                gap_cur = 1;
            end else if (gap_run) begin
                if (!m_busy) gap_cur++;
                else begin
                    if (gap_cur > gap_max) gap_max = gap_cur;
                    gap_run = 1'b0;
                end
            end
        end
        p_din  = m_din;
        p_clk  = m_clk;
        p_load = m_load;
        p_done = m_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"},  {31'd0, din1},  32'd0);
        chk({tag, "_clk"},  {31'd0, clk1},  32'd0);
        chk({tag, "_load"}, {31'd0, load1}, 32'd0);
        chk({tag, "_sel"},  {29'd0, sel1},  32'd0);
        chk({tag, "_busy"}, {31'd0, busy1}, 32'd1);
        chk({tag, "_done"}, {31'd0, done1}, 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int bound, output int n);
        n = 0;
        while (m_busy !== 1'b0 && n < bound) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, n < bound}, 32'd1);
    endtask

    // Reference frames derived from the register map, not from the RTL
    task automatic init_expect(input logic [3:0] inten, output logic [15:0] q [$]);
        q = {};
        q.push_back(16'h0C01);
        q.push_back(16'h0900);
        q.push_back({8'h0A, 4'h0, inten});
        q.push_back(16'h0B07);
        q.push_back(16'h0F00);
    endtask

    task automatic refresh_expect(input int reps, output logic [15:0] q [$]);
        q = {};
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < 8; i++)
                q.push_back({4'h0, 4'(i + 1), col_mem[i]});
    endtask

    task automatic cmp_frames(input string tag, input logic [15:0] q [$]);
        chk({tag, "_count"}, frames.size(), q.size());
        for (int i = 0; i < q.size() && i < frames.size(); i++)
            chk($sformatf("%s_frame%0d", tag, i), {16'd0, frames[i]}, {16'd0, q[i]});
    endtask

    task automatic pulse_start1();
        @(negedge CLOCK_50) start1 = 1'b1;
        @(negedge CLOCK_50) start1 = 1'b0;
    endtask

    logic [15:0] expq [$];
    int n, seen;

    initial begin
        for (int i = 0; i < 8; i++) col_mem[i] = 8'hA0 + 8'(i);

        // Reset held: outputs stay at reset values
        repeat (2) @(negedge CLOCK_50);
        for (int k = 0; k < 3; k++) begin
            chk_reset_outputs("reset_hold");
            @(negedge CLOCK_50);
        end

        // Init sequence, with a start pulse during init that must be ignored
        frames = {};
        done_count = 0;
        rst1 = 1'b0;
        repeat (200) @(negedge CLOCK_50);
        pulse_start1();
        wait_idle("init", 2000, n);
        n = n + 202;
        chk("init_clocks_min", {31'd0, n >= 680}, 32'd1);
        chk("init_clocks_max", {31'd0, n <= 700}, 32'd1);
        init_expect(4'h8, expq);
        cmp_frames("init", expq);
        chk("init_done", done_count, 32'd0);
        repeat (20) @(negedge CLOCK_50);
        chk("init_no_queue_busy", {31'd0, busy1}, 32'd0);

        // Refresh with column = A0 + sel, extra start mid-refresh
        frames = {};
        done_count = 0;
        pulse_start1();
        repeat (300) @(negedge CLOCK_50);
        pulse_start1();
        wait_idle("ref_a0", 3000, n);
        refresh_expect(1, expq);
        cmp_frames("ref_a0", expq);
        repeat (20) @(negedge CLOCK_50);
        chk("ref_a0_done", done_count, 32'd1);
        chk("ref_a0_busy", {31'd0, busy1}, 32'd0);
        chk("ref_a0_frames_after", frames.size(), 32'd8);

        // Randomized column data
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 8; i++) col_mem[i] = 8'($urandom);
            frames = {};
            done_count = 0;
            pulse_start1();
            wait_idle("ref_rand", 3000, n);
            refresh_expect(1, expq);
            cmp_frames($sformatf("ref_rand%0d", t), expq);
            @(negedge CLOCK_50);
            chk("ref_rand_done", done_count, 32'd1);
        end

        // Reset mid-frame at bit 9 of row 3
        frames = {};
        pulse_start1();
        n = 0;
        while (!(frames.size() == 3 && bitcnt == 9) && n < 5000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("midreset_reach", {31'd0, n < 5000}, 32'd1);
        rst1 = 1'b1;
        @(negedge CLOCK_50);
        chk_reset_outputs("midreset_next");
        repeat (3) @(negedge CLOCK_50);
        chk_reset_outputs("midreset_hold");
        chk("midreset_no_latch", frames.size(), 32'd3);
        frames = {};
        done_count = 0;
        rst1 = 1'b0;
        wait_idle("reinit", 2000, n);
        init_expect(4'h8, expq);
        cmp_frames("reinit", expq);
        chk("reinit_done", done_count, 32'd0);

        // Second instance, CLK_DIV=2: init then start held for two refreshes
        @(negedge CLOCK_50);
        mon_sel = 1'b1;
        @(negedge CLOCK_50);
        frames = {};
        done_count = 0;
        rst2 = 1'b0;
        wait_idle("init2", 1000, n);
        init_expect(4'h3, expq);
        cmp_frames("init2", expq);
        for (int i = 0; i < 8; i++) col_mem[i] = 8'($urandom);
        frames = {};
        done_count = 0;
        gap_max = 0;
        start2 = 1'b1;
        seen = 0;
        n = 0;
        while (seen < 2 && n < 4000) begin
            @(negedge CLOCK_50);
            if (done2) seen++;
            n++;
        end
        start2 = 1'b0;
        chk("b2b_timeout", {31'd0, n < 4000}, 32'd1);
        repeat (10) @(negedge CLOCK_50);
        refresh_expect(2, expq);
        cmp_frames("b2b", expq);
        chk("b2b_done", done_count, 32'd2);
        chk("b2b_gap_min", {31'd0, gap_max >= 1}, 32'd1);
        chk("b2b_gap_max", {31'd0, gap_max <= 2}, 32'd1);
        chk("b2b_busy_after", {31'd0, busy2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
